// File: rtl/call_cache_responder_pkg.sv
// Shared types and defaults for the call-cache responder.
package definitions;

  localparam int unsigned CALL_CACHE_DEPTH = 32;

  typedef enum logic {
    CACHE_PUSH = 1'b0,
    CACHE_POP  = 1'b1
  } cache_op_e;

  typedef enum logic [1:0] {
    CC_IDLE,
    CC_PUSH_HI,
    CC_POP_LO,
    CC_DONE
  } cc_state_e;

endpackage

// File: rtl/call_cache_responder_ram.sv
// Byte-wide single-port call-cache RAM: asynchronous read, synchronous write.
module call_cache_ram #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned AW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/call_cache_responder.sv
// Two-cycle call-cache responder: saves/restores 16-bit PCs as byte pairs.
// Optional peak-occupancy tracking enabled by defining CALL_CACHE_STATS_EN.
module call_cache_responder
  import definitions::*;
#(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned DEPTH = CALL_CACHE_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic                    req_op,
  input  logic [15:0]             req_pc,
  output logic                    req_ready,
  output logic                    pop_valid,
  output logic [15:0]             pop_pc,
  output logic                    err,
  output logic                    full,
  output logic                    empty
`ifdef CALL_CACHE_STATS_EN
  , output logic [$clog2(DEPTH):0] high_water
`endif
);

  localparam int unsigned AW = $clog2(2 * DEPTH);
  localparam int unsigned PW = AW + 1;

  if (PC_W != 16) begin : g_bad_pc_w
    $error("call_cache_responder: PC_W must be 16");
  end
  if ((DEPTH == 0) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("call_cache_responder: DEPTH must be a power of 2");
  end

  cc_state_e      state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [7:0]     hi_q, hi_d;
  logic [15:0]    pop_pc_q, pop_pc_d;
  logic           err_q, err_d;

  logic           ram_we;
  logic [AW-1:0]  ram_addr;
  logic [7:0]     ram_wdata;
  logic [7:0]     ram_rdata;
  logic [AW-1:0]  ptr_lo;

  assign ptr_lo = ptr_q[AW-1:0];

  call_cache_ram #(
    .ENTRIES (2 * DEPTH),
    .AW      (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hi_d      = hi_q;
    pop_pc_d  = pop_pc_q;
    err_d     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = ptr_lo;
    ram_wdata = hi_q;
    unique case (state_q)
      CC_IDLE: begin
        if (req_valid) begin
          if (cache_op_e'(req_op) == CACHE_PUSH) begin
            if (full) begin
              err_d = 1'b1;
            end else begin
              ram_we    = 1'b1;
              ram_wdata = req_pc[7:0];
              hi_d      = req_pc[15:8];
              state_d   = CC_PUSH_HI;
            end
          end else begin
            if (empty) begin
              err_d = 1'b1;
            end else begin
              ram_addr = ptr_lo - AW'(1);
              hi_d     = ram_rdata;
              state_d  = CC_POP_LO;
            end
          end
        end
      end
      CC_PUSH_HI: begin
        ram_we   = 1'b1;
        ram_addr = ptr_lo + AW'(1);
        ptr_d    = ptr_q + PW'(2);
        state_d  = CC_IDLE;
      end
      CC_POP_LO: begin
        ram_addr = ptr_lo - AW'(2);
        pop_pc_d = {hi_q, ram_rdata};
        ptr_d    = ptr_q - PW'(2);
        state_d  = CC_DONE;
      end
      CC_DONE: begin
        state_d = CC_IDLE;
      end
      default: state_d = CC_IDLE;
    endcase
  end

  // RAM contents survive reset; clearing ptr is what discards any partial entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CC_IDLE;
      ptr_q    <= '0;
      hi_q     <= '0;
      pop_pc_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hi_q     <= hi_d;
      pop_pc_q <= pop_pc_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = (state_q == CC_IDLE);
  assign pop_valid = (state_q == CC_DONE);
  assign pop_pc    = pop_pc_q;
  assign err       = err_q;
  assign full      = (ptr_q == PW'(2 * DEPTH));
  assign empty     = (ptr_q == '0);

`ifdef CALL_CACHE_STATS_EN
  logic                   push_done_q;
  logic [$clog2(DEPTH):0] hw_q;
  logic [PW-2:0]          count;

  assign count = ptr_q[PW-1:1];

  // Count never exceeds DEPTH, so the max naturally saturates there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      push_done_q <= 1'b0;
      hw_q        <= '0;
    end else begin
      push_done_q <= (state_q == CC_PUSH_HI);
      if (push_done_q && (count > hw_q)) hw_q <= count;
    end
  end

  assign high_water = hw_q;
`endif

endmodule

// File: tb/tb_call_cache_responder.sv
// Directed scoreboard bench for call_cache_responder.
module tb_call_cache_responder;

  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_op;
  logic [15:0] req_pc;
  logic        req_ready;
  logic        pop_valid;
  logic [15:0] pop_pc;
  logic        err;
  logic        full;
  logic        empty;
`ifdef CALL_CACHE_STATS_EN
  logic [$clog2(DEPTH):0] high_water;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] model[$];
  logic [15:0] exp_q[$];

  call_cache_responder #(
    .PC_W  (16),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_pc     (req_pc),
    .req_ready  (req_ready),
    .pop_valid  (pop_valid),
    .pop_pc     (pop_pc),
    .err        (err),
    .full       (full),
    .empty      (empty)
`ifdef CALL_CACHE_STATS_EN
    , .high_water (high_water)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every restored PC must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (pop_valid) begin
      if (exp_q.size() == 0) chk("unexpected_pop_valid", 32'd1, 32'd0);
      else chk("pop_pc", {16'd0, pop_pc}, {16'd0, exp_q.pop_front()});
    end
  end

  // Issue one request at a negedge with req_ready high, then check err,
  // busy length and pop latency against the reference stack.
  task automatic op_req(input logic op, input logic [15:0] pc, input string tag);
    logic legal;
    int busy;
    int pv_at;
    int n;
    logic [15:0] pc_before;
    busy  = 0;
    pv_at = -1;
    n     = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    legal = (op == 1'b0) ? (model.size() < DEPTH) : (model.size() > 0);
    pc_before = pop_pc;
    req_valid = 1'b1;
    req_op    = op;
    req_pc    = pc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (legal) begin
      if (op == 1'b0) model.push_back(pc);
      else exp_q.push_back(model.pop_back());
    end
    @(negedge clk);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, !legal});
    for (int i = 1; i <= 6; i++) begin
      if (pop_valid) pv_at = i;
      if (req_ready) break;
      busy++;
      @(negedge clk);
    end
    chk({tag, "_busy"}, busy, legal ? (op ? 2 : 1) : 0);
    chk({tag, "_pop_lat"}, pv_at, (legal && op) ? 2 : -1);
    if (!legal && op) chk({tag, "_pop_pc_hold"}, {16'd0, pop_pc}, {16'd0, pc_before});
    chk({tag, "_empty"}, {31'd0, empty}, {31'd0, model.size() == 0});
    chk({tag, "_full"}, {31'd0, full}, {31'd0, model.size() == DEPTH});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_pc    = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_pop_valid", {31'd0, pop_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_pop_pc", {16'd0, pop_pc}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op_req(1'b0, 16'hBEEF, "push_beef");
    op_req(1'b1, 16'h0000, "pop_beef");

    op_req(1'b0, 16'h1234, "push_1234");
    op_req(1'b0, 16'hABCD, "push_abcd");
    op_req(1'b1, 16'h0000, "pop_abcd");
    op_req(1'b1, 16'h0000, "pop_1234");

    for (int i = 0; i < DEPTH; i++) op_req(1'b0, 16'h0A00 + 16'(i * 16'h0107), "fill");
    op_req(1'b0, 16'h5555, "push_full");
    op_req(1'b1, 16'h0000, "pop_after_full");
    for (int i = 1; i < DEPTH; i++) op_req(1'b1, 16'h0000, "drain");

    op_req(1'b1, 16'h0000, "pop_empty");

    // Reset while the high byte of a push is pending.
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_pc    = 16'hCAFE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    op_req(1'b1, 16'h0000, "pop_after_rst");

`ifdef CALL_CACHE_STATS_EN
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    model.delete();
    chk("hw_rst", 32'(high_water), 32'd0);
    for (int i = 0; i < 5; i++) op_req(1'b0, 16'h7000 + 16'(i), "hw_push");
    for (int i = 0; i < 3; i++) op_req(1'b1, 16'h0000, "hw_pop");
    op_req(1'b0, 16'h7777, "hw_push_last");
    @(negedge clk);
    chk("high_water", 32'(high_water), 32'd5);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
